// File: rtl/mdl_axis_pkt_fifo.sv
// AXI4-Stream FWFT FIFO with optional store-and-forward packet gating.
// A forced cut-through fallback releases packets longer than the FIFO.
module mdl_axis_pkt_fifo #(
    parameter int PRM_DAXI     = 64,
    parameter int PRM_DKEEP    = 8,
    parameter int PRM_DEPTH    = 16,
    parameter int PRM_AW       = 4,
    parameter int PRM_PKT_MODE = 1
) (
    input  logic                 iSYS_CLK,
    input  logic                 iSYS_RST,
    input  logic                 iS_AXIS_TVALID,
    output logic                 oS_AXIS_TREADY,
    input  logic [PRM_DAXI-1:0]  iS_AXIS_TDATA,
    input  logic [PRM_DKEEP-1:0] iS_AXIS_TKEEP,
    input  logic                 iS_AXIS_TLAST,
    output logic                 oM_AXIS_TVALID,
    input  logic                 iM_AXIS_TREADY,
    output logic [PRM_DAXI-1:0]  oM_AXIS_TDATA,
    output logic [PRM_DKEEP-1:0] oM_AXIS_TKEEP,
    output logic                 oM_AXIS_TLAST,
    output logic [PRM_AW:0]      oFIFO_LEVEL,
    output logic [PRM_AW:0]      oFIFO_PKTS
);
    localparam int              W       = PRM_DAXI + PRM_DKEEP + 1;
    localparam logic [PRM_AW:0] DEPTH_L = (PRM_AW + 1)'(PRM_DEPTH);

    logic [W-1:0]      mem_q [PRM_DEPTH];
    logic [W-1:0]      head;
    logic [PRM_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PRM_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PRM_AW:0]   level_q, level_d;
    logic [PRM_AW:0]   pkts_q, pkts_d;
    logic              force_q, force_d;
    logic              s_tready_q, s_tready_d;
    logic              push, pop, head_last, m_tvalid;

    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[0];

    // Head is held until popped: level, pkts and force can only shrink on a pop.
    assign m_tvalid = (level_q != '0) &
                      ((PRM_PKT_MODE == 0) | (pkts_q != '0) | force_q);

    assign oS_AXIS_TREADY = s_tready_q;
    assign oM_AXIS_TVALID = m_tvalid;
    assign {oM_AXIS_TDATA, oM_AXIS_TKEEP, oM_AXIS_TLAST} = head;
    assign oFIFO_LEVEL    = level_q;
    assign oFIFO_PKTS     = pkts_q;

    always_comb begin
        push       = iS_AXIS_TVALID & s_tready_q;
        pop        = m_tvalid & iM_AXIS_TREADY;
        wr_ptr_d   = push ? wr_ptr_q + PRM_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PRM_AW'(1) : rd_ptr_q;
        level_d    = level_q + (PRM_AW + 1)'(push) - (PRM_AW + 1)'(pop);
        pkts_d     = pkts_q + (PRM_AW + 1)'(push & iS_AXIS_TLAST)
                            - (PRM_AW + 1)'(pop & head_last);
        s_tready_d = (level_d < DEPTH_L);
        force_d    = force_q;
        // Full with no complete packet: release the oversized packet as cut-through.
        if (pop & head_last) begin
            force_d = 1'b0;
        end else if ((level_q == DEPTH_L) && (pkts_q == '0)) begin
            force_d = 1'b1;
        end
    end

    always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
        if (iSYS_RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pkts_q     <= '0;
            force_q    <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pkts_q     <= pkts_d;
            force_q    <= force_d;
            s_tready_q <= s_tready_d;
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {iS_AXIS_TDATA, iS_AXIS_TKEEP, iS_AXIS_TLAST};
        end
    end
endmodule

// File: tb/tb_mdl_axis_pkt_fifo.sv
// Bench for mdl_axis_pkt_fifo: queue-based reference model with a negedge monitor,
// directed reset/store-forward/full/streaming cases, random traffic and a FWFT instance.
module tb_mdl_axis_pkt_fifo;
    localparam int DEPTH = 16;
    localparam int TMO   = 2000;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        m_valid, m_ready = 1'b0, m_last;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic [4:0]  level, pkts;

    logic        f_s_valid = 1'b0, f_s_ready, f_m_valid, f_m_last;
    logic [63:0] f_s_data = '0, f_m_data;
    logic [7:0]  f_m_keep;
    logic [4:0]  f_level, f_pkts;

    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];
    int    m_lvl = 0, m_pkts = 0;
    bit    m_force = 0, prev_stall = 0, rdy_known = 0, t5_done = 0;
    beat_t prev_head, exp_b;
    bit    do_push, do_pop, e_last, exp_v;

    always #5 clk = ~clk;

    mdl_axis_pkt_fifo #(.PRM_DAXI(64), .PRM_DKEEP(8), .PRM_DEPTH(DEPTH), .PRM_AW(4),
                        .PRM_PKT_MODE(1)) u_dut (
        .iSYS_CLK(clk), .iSYS_RST(rst),
        .iS_AXIS_TVALID(s_valid), .oS_AXIS_TREADY(s_ready), .iS_AXIS_TDATA(s_data),
        .iS_AXIS_TKEEP(s_keep), .iS_AXIS_TLAST(s_last),
        .oM_AXIS_TVALID(m_valid), .iM_AXIS_TREADY(m_ready), .oM_AXIS_TDATA(m_data),
        .oM_AXIS_TKEEP(m_keep), .oM_AXIS_TLAST(m_last),
        .oFIFO_LEVEL(level), .oFIFO_PKTS(pkts)
    );

    mdl_axis_pkt_fifo #(.PRM_DAXI(64), .PRM_DKEEP(8), .PRM_DEPTH(DEPTH), .PRM_AW(4),
                        .PRM_PKT_MODE(0)) u_fwft (
        .iSYS_CLK(clk), .iSYS_RST(rst),
        .iS_AXIS_TVALID(f_s_valid), .oS_AXIS_TREADY(f_s_ready), .iS_AXIS_TDATA(f_s_data),
        .iS_AXIS_TKEEP(8'hFF), .iS_AXIS_TLAST(1'b0),
        .oM_AXIS_TVALID(f_m_valid), .iM_AXIS_TREADY(1'b0), .oM_AXIS_TDATA(f_m_data),
        .oM_AXIS_TKEEP(f_m_keep), .oM_AXIS_TLAST(f_m_last),
        .oFIFO_LEVEL(f_level), .oFIFO_PKTS(f_pkts)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TREADY is only predictable once the DUT has seen a clock edge out of reset.
    always @(posedge clk) rdy_known = !rst;

    // Reference model: FIFO contents are the scoreboard queue; counters follow the handshakes.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_lvl = 0; m_pkts = 0; m_force = 0; prev_stall = 0;
        end else begin
            exp_v = (m_lvl != 0) && ((m_pkts != 0) || m_force);
            chk("level", 64'(level), 64'(m_lvl));
            chk("pkts", 64'(pkts), 64'(m_pkts));
            chk("m_tvalid", 64'(m_valid), 64'(exp_v));
            if (rdy_known) chk("s_tready", 64'(s_ready), 64'(m_lvl < DEPTH));
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", m_data, prev_head.d);
                chk("hold_keep_last", 64'({m_keep, m_last}), 64'({prev_head.k, prev_head.l}));
            end
            do_push = s_valid && s_ready;
            do_pop  = m_valid && m_ready;
            e_last  = 1'b0;
            if (do_pop) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_b = sb.pop_front();
                    chk("pop_data", m_data, exp_b.d);
                    chk("pop_keep", 64'(m_keep), 64'(exp_b.k));
                    chk("pop_last", 64'(m_last), 64'(exp_b.l));
                    e_last = exp_b.l;
                end
            end
            if (do_pop && e_last) m_force = 0;
            else if (m_lvl == DEPTH && m_pkts == 0) m_force = 1;
            m_lvl  = m_lvl + int'(do_push) - int'(do_pop);
            m_pkts = m_pkts + int'(do_push && s_last) - int'(do_pop && e_last);
            prev_stall = m_valid && !m_ready;
            prev_head  = '{d: m_data, k: m_keep, l: m_last};
        end
    end

    task automatic send_beat(input beat_t b, input int unsigned idle);
        for (int unsigned i = 0; i < idle; i++) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = b.d; s_keep = b.k; s_last = b.l;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_ready) break;
            if (n >= TMO) begin
                chk("push_timeout", 64'd0, 64'd1);
                s_valid = 1'b0;
                return;
            end
        end
        sb.push_back(b);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int n = 0; n < TMO && level != 0; n++) @(negedge clk);
        chk({name, "_level"}, 64'(level), 64'd0);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.k = 8'($urandom);
        b.l = last;
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int len;
        do_reset();

        // T1: reset mid-stream with five beats stored, one packet complete.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(rnd_beat(i == 2), 0);
        chk("t1_level_pre", 64'(level), 64'd5);
        chk("t1_tvalid_pre", 64'(m_valid), 64'd1);
        rst = 1'b1; #1;
        chk("t1_tvalid_rst", 64'(m_valid), 64'd0);
        chk("t1_level_rst", 64'(level), 64'd0);
        chk("t1_pkts_rst", 64'(pkts), 64'd0);
        chk("t1_tready_rst", 64'(s_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0; #1;
        chk("t1_tready_release", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        chk("t1_tready_after_edge", 64'(s_ready), 64'd1);

        // T2: store-and-forward of a three-beat packet.
        do_reset();
        send_beat('{d: 64'h11, k: 8'hFF, l: 1'b0}, 0);
        send_beat('{d: 64'h22, k: 8'hFF, l: 1'b0}, 0);
        chk("t2_tvalid_partial", 64'(m_valid), 64'd0);
        send_beat('{d: 64'h33, k: 8'hFF, l: 1'b1}, 0);
        chk("t2_tvalid_complete", 64'(m_valid), 64'd1);
        chk("t2_head", m_data, 64'h11);
        chk("t2_pkts", 64'(pkts), 64'd1);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("t2_pkts_after", 64'(pkts), 64'd0);
        chk("t2_level_after", 64'(level), 64'd0);

        // T3: fill with an unterminated packet; force cut-through drains it.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_beat(rnd_beat(1'b0), 0);
        chk("t3_level_full", 64'(level), 64'd16);
        chk("t3_tready_full", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        chk("t3_forced_tvalid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        send_beat(rnd_beat(1'b1), 0);
        drain("t3_drain");
        m_ready = 1'b0;
        send_beat(rnd_beat(1'b0), 0);
        repeat (2) @(posedge clk);
        #1 chk("t3_force_cleared", 64'(m_valid), 64'd0);

        // T4: level 8, push and pop every cycle for 50 cycles.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(rnd_beat((i % 4) == 3), 0);
        m_ready = 1'b1;
        for (int i = 8; i < 58; i++) begin
            send_beat(rnd_beat((i % 4) == 3), 0);
            chk("t4_level_steady", 64'(level), 64'd8);
        end
        m_ready = 1'b0;
        @(posedge clk); #1;
        chk("t4_level_end", 64'(level), 64'd8);

        // T5: random traffic, packets of 1..40 beats, random backpressure.
        do_reset();
        t5_done = 0;
        fork
            begin
                total = 0;
                while (total < 1000) begin
                    len = int'($urandom_range(1, 40));
                    for (int i = 0; i < len; i++)
                        send_beat(rnd_beat(i == len - 1), $urandom_range(0, 1));
                    total += len;
                end
                t5_done = 1;
            end
            begin
                while (!t5_done) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("t5_drain");
        m_ready = 1'b0;

        // T6: plain FWFT instance releases a beat without TLAST.
        do_reset();
        f_s_valid = 1'b1; f_s_data = 64'hDEAD;
        @(negedge clk);
        chk("t6_accept", 64'(f_s_ready), 64'd1);
        chk("t6_no_bypass", 64'(f_m_valid), 64'd0);
        @(posedge clk); #1 f_s_valid = 1'b0;
        chk("t6_tvalid", 64'(f_m_valid), 64'd1);
        chk("t6_data", f_m_data, 64'hDEAD);
        chk("t6_last", 64'(f_m_last), 64'd0);
        chk("t6_level", 64'(f_level), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
